// File: rtl/socket_frame_arbiter.sv
// Round-robin frame arbiter: grants one upstream FWFT FIFO at a time for a whole frame.
// Optional stall timeout/abort is enabled with the SOCKET_ARB_TIMEOUT_EN macro.
module socket_frame_arbiter #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned IdW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_SRC-1:0]        i_empty,
  input  logic [N_SRC*DATA_W-1:0] i_data,
  output logic [N_SRC-1:0]        o_rd_en,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic                    o_eof,
  output logic [IdW-1:0]          o_src_id,
  output logic                    o_busy,
  output logic                    o_abort
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic [IdW-1:0]    src_q;
  logic              valid_q, sof_q, eof_q;
  logic              pop;
  logic              found;
  logic [IdW-1:0]    pick;
  logic              abort_d;

  assign pop = (state_q == StXfer) & ~i_empty[grant_q] & i_ready;

  // First non-empty source after the last one served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      logic [IdW-1:0] idx;
      idx = IdW'((32'(rr_ptr_q) + off) % N_SRC);
      if (!found && !i_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    o_rd_en = '0;
    if (pop) o_rd_en[grant_q] = 1'b1;
  end

`ifdef SOCKET_ARB_TIMEOUT_EN
  localparam int unsigned StW = $clog2(TIMEOUT_CYC + 1);
  logic [StW-1:0] stall_q, stall_d;
  logic           stall_empty;
  logic           abort_q;

  // Only an empty source ages the frame; downstream back-pressure holds the count.
  assign stall_empty = (state_q == StXfer) & i_empty[grant_q] & i_ready;

  always_comb begin
    stall_d = stall_q;
    abort_d = 1'b0;
    if (state_q != StXfer || pop) begin
      stall_d = '0;
    end else if (stall_empty) begin
      if (stall_q == StW'(TIMEOUT_CYC - 1)) begin
        stall_d = '0;
        abort_d = 1'b1;
      end else begin
        stall_d = stall_q + StW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign o_abort = abort_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign abort_d        = 1'b0;
  assign o_abort        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (pop) begin
          if (cnt_q == CntLast) begin
            cnt_d    = '0;
            rr_ptr_d = grant_q;
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (abort_d) begin
          cnt_d    = '0;
          rr_ptr_d = grant_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= IdW'(N_SRC - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= pop;
      sof_q   <= pop && (cnt_q == '0);
      eof_q   <= pop && (cnt_q == CntLast);
      if (pop) begin
        data_q <= i_data[grant_q*DATA_W +: DATA_W];
        src_q  <= grant_q;
      end
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_sof    = sof_q;
  assign o_eof    = eof_q;
  assign o_src_id = src_q;
  assign o_busy   = (state_q == StXfer);

endmodule

// File: tb/tb_socket_frame_arbiter.sv
// Bench for socket_frame_arbiter: FIFO model plus output scoreboard, table-driven frame orders
// and hand sequences for idle, stalls, back-pressure and (with SOCKET_ARB_TIMEOUT_EN) abort.
module tb_socket_frame_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FL = 16;
`ifdef SOCKET_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_empty;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_rd_en;
  logic           i_ready;
  logic [W-1:0]   o_data;
  logic           o_valid, o_sof, o_eof, o_busy, o_abort;
  logic [1:0]     o_src_id;

  socket_frame_arbiter #(
    .N_SRC(N), .DATA_W(W), .FRAME_LEN(FL), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_empty(i_empty), .i_data(i_data), .o_rd_en(o_rd_en),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_src_id(o_src_id), .o_busy(o_busy), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {logic [W-1:0] data; logic [1:0] src; logic sof; logic eof;} beat_t;
  typedef struct {int load[N]; int order[8]; int nfr;} vec_t;

  beat_t        sb[$];
  int           ld_seq[N], rd_seq[N], exp_seq[N];
  int           n_vec = 0, n_err = 0;
  int           cyc = 0, first_v, last_v, first_rd;
  logic [N-1:0] first_rd_vec, last_rd;

  function automatic logic [W-1:0] word(int s, int q);
    return 8'(s * 64 + (q % 64));
  endfunction

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      i_empty[k]       = (rd_seq[k] == ld_seq[k]);
      i_data[k*W +: W] = word(k, rd_seq[k]);
    end
  endtask

  task automatic check(string name, logic ok, int act, int req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at negedge: sample pops, clock, update FIFO model, then score outputs.
  task automatic tick();
    logic [N-1:0] rd;
    beat_t e, g;
    #1;
    rd = o_rd_en;
    last_rd = rd;
    check("rd_en_onehot_nonempty", $onehot0(rd) && ((rd & i_empty) == '0), int'(rd), 0);
    if (rd != '0 && first_rd < 0) begin
      first_rd = cyc;
      first_rd_vec = rd;
    end
    @(posedge i_clk); #1;
    for (int k = 0; k < N; k++) if (rd[k]) rd_seq[k]++;
    cyc++;
    refresh();
    @(negedge i_clk);
    if (o_valid) begin
      g = {o_data, o_src_id, o_sof, o_eof};
      if (sb.size() == 0) begin
        check("unexpected_beat", 1'b0, int'(g), 0);
      end else begin
        e = sb.pop_front();
        check("beat", g == e, int'(g), int'(e));
      end
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic expect_beats(int s, int n, bit full);
    for (int i = 0; i < n; i++) begin
      sb.push_back({word(s, exp_seq[s]), 2'(s), i == 0, full && (i == FL - 1)});
      exp_seq[s]++;
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (ld_seq[k] != rd_seq[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    i_rst   = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      ld_seq[k] = 0; rd_seq[k] = 0; exp_seq[k] = 0;
    end
    sb.delete();
    refresh();
    first_v  = -1;
    first_rd = -1;
    #2;
    check("reset_outputs",
          {o_rd_en, o_valid, o_sof, o_eof, o_data, o_src_id, o_busy, o_abort} == '0,
          int'({o_rd_en, o_valid, o_sof, o_eof, o_data, o_src_id, o_busy, o_abort}), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic run_drain(int budget);
    int n = 0;
    while ((sb.size() != 0 || pending()) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", n < budget, n, budget);
  endtask

  task automatic wait_pops(int s, int cnt, int budget);
    int n = 0;
    while (rd_seq[s] < cnt && n < budget) begin
      tick();
      n++;
    end
    check("pops_reached", rd_seq[s] >= cnt, rd_seq[s], cnt);
  endtask

  vec_t vt[4];

  initial begin
    int c0;
    i_rst = 1'b1;
    vt[0].load = '{0, 0, 16, 0};    vt[0].order = '{2, 0, 0, 0, 0, 0, 0, 0}; vt[0].nfr = 1;
    vt[1].load = '{32, 32, 32, 32}; vt[1].order = '{0, 1, 2, 3, 0, 1, 2, 3}; vt[1].nfr = 8;
    vt[2].load = '{16, 0, 0, 16};   vt[2].order = '{0, 3, 0, 0, 0, 0, 0, 0}; vt[2].nfr = 2;
    vt[3].load = '{0, 16, 16, 0};   vt[3].order = '{1, 2, 0, 0, 0, 0, 0, 0}; vt[3].nfr = 2;

    // Idle with nothing to do.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", last_rd == '0 && !o_valid && !o_busy,
            int'({last_rd, o_valid, o_busy}), 0);
    end

    // Frame order table: each row starts from reset so source 0 has first priority.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      c0 = cyc;
      for (int k = 0; k < N; k++) ld_seq[k] = vt[r].load[k];
      refresh();
      for (int f = 0; f < vt[r].nfr; f++) expect_beats(vt[r].order[f], FL, 1'b1);
      run_drain(400);
      check("first_pop_cycle", first_rd == c0 + 1, first_rd - c0, 1);
      check("first_pop_src", first_rd_vec == N'(1 << vt[r].order[0]),
            int'(first_rd_vec), 1 << vt[r].order[0]);
      check("frame_span", last_v - first_v == vt[r].nfr * (FL + 1) - 2,
            last_v - first_v, vt[r].nfr * (FL + 1) - 2);
    end

`ifndef SOCKET_ARB_TIMEOUT_EN
    // Source 1 runs dry mid-frame; source 3 must not be granted meanwhile.
    do_reset();
    ld_seq[1] = 5;
    ld_seq[3] = 16;
    refresh();
    expect_beats(1, FL, 1'b1);
    expect_beats(3, FL, 1'b1);
    wait_pops(1, 5, 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_stall_hold", last_rd == '0 && o_busy, int'({last_rd, o_busy}), 1);
    end
    ld_seq[1] = 16;
    refresh();
    run_drain(200);
`endif

    // Downstream back-pressure mid-frame.
    do_reset();
    ld_seq[0] = 16;
    refresh();
    expect_beats(0, FL, 1'b1);
    wait_pops(0, 6, 20);
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ready_stall", last_rd == '0 && !o_valid, int'({last_rd, o_valid}), 0);
    end
    i_ready = 1'b1;
    run_drain(100);

`ifdef SOCKET_ARB_TIMEOUT_EN
    begin
      int n;
      do_reset();
      ld_seq[0] = 3;
      ld_seq[1] = 16;
      refresh();
      expect_beats(0, 3, 1'b0);
      expect_beats(1, FL, 1'b1);
      wait_pops(0, 3, 20);
      n = 0;
      while (!o_abort && n < 20) begin
        tick();
        n++;
      end
      check("abort_delay", o_abort && n == TO, n, TO);
      run_drain(100);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/socket_frame_arbiter.md
Name: socket_frame_arbiter

Overview:
- Round-robin scheduler that shares one downstream processing socket between N_SRC upstream socket FIFOs.
- Grants one source at a time for a complete frame of FRAME_LEN words and drives that source's read enable.
- Forwards the popped words with frame delimiters and the source index.
- Sits between the per-task output FIFOs and the shared decoder/encoder stage input FIFO.

Parameters:
- N_SRC, 4, number of upstream source FIFOs (≥2).
- DATA_W, 8, word width in bits.
- FRAME_LEN, 16, words per frame (≥1).
- TIMEOUT_CYC, 64, stall-cycle limit; used only with SOCKET_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_empty  in  N_SRC  per-source FIFO empty flag; FIFOs are first-word-fall-through.
- i_data  in  N_SRC*DATA_W  per-source head word; source k occupies bits [k*DATA_W +: DATA_W].
- o_rd_en  out  N_SRC  per-source pop strobe, one-hot or zero.
- i_ready  in  1  downstream can accept; derived from almost-full with ≥1 word of slack.
- o_data  out  DATA_W  registered output word.
- o_valid  out  1  o_data valid this cycle.
- o_sof  out  1  first word of frame, qualified by o_valid.
- o_eof  out  1  last word of frame, qualified by o_valid.
- o_src_id  out  max(1,$clog2(N_SRC))  source index of current o_data.
- o_busy  out  1  frame in progress (state ST_XFER).
- o_abort  out  1  one-cycle pulse when a frame is aborted; tied 0 without SOCKET_ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous): state=ST_IDLE, grant=0, rr_ptr=N_SRC-1 (so source 0 has first priority), word counter=0.
- Reset values of outputs: o_rd_en=0, o_valid=0, o_sof=0, o_eof=0, o_data=0, o_src_id=0, o_busy=0, o_abort=0.
- ST_IDLE: scan sources rr_ptr+1, rr_ptr+2, … modulo N_SRC for the first one with i_empty=0.
  - If found: latch grant=k, cnt=0, go to ST_XFER on the next edge.
  - If none found: stay in ST_IDLE.
  - o_rd_en=0 throughout ST_IDLE.
- ST_XFER:
  - o_rd_en[grant] = ~i_empty[grant] & i_ready (combinational). All other bits are 0.
  - Each pop increments cnt.
  - On a pop with cnt==FRAME_LEN-1: cnt←0, rr_ptr←grant, go to ST_IDLE.
  - Source empty or i_ready low mid-frame: stall with grant held. The frame is atomic and no other source is granted.
- Output register, updated at the pop edge (latency 1 cycle):
  - o_valid = pop.
  - o_data = i_data[grant].
  - o_src_id = grant.
  - o_sof = (cnt==0).
  - o_eof = (cnt==FRAME_LEN-1).
  - FRAME_LEN=1: o_sof and o_eof are both set on the single word.
- Throughput:
  - One idle bubble cycle between consecutive frames (the ST_IDLE arbitration cycle).
  - Within a frame, one word per cycle while the source is non-empty and i_ready=1.
- Fairness: a source that just finished a frame has lowest priority for the next arbitration.
  - All sources continuously requesting → grant order 0,1,2,3,0,…
- The counter width holds 0..FRAME_LEN-1 with no wrap beyond the last word.
- Reset mid-frame: partial frame is dropped downstream of the arbiter. Words already popped are lost; no o_eof is emitted.
- i_empty changing in the same cycle as the arbitration decision: the sampled value in that cycle decides.

Optional Feature:
- Macro: SOCKET_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter increments in every ST_XFER cycle without a pop and clears on each pop.
  - When it reaches TIMEOUT_CYC: o_abort pulses for 1 cycle, rr_ptr←grant, cnt←0, go to ST_IDLE.
  - No o_eof is emitted for the aborted frame.
  - A stall caused by i_ready=0 does not count; only a source empty stall does.
- Not defined: no stall counter; the arbiter waits indefinitely mid-frame; o_abort is constant 0.

Test Plan:
- Reset, all i_empty=1 → o_rd_en=0 and o_valid=0 for 20 cycles; o_busy=0.
- Only source 2 non-empty with 16 words, i_ready=1 → grant 1 cycle after request.
  - 16 consecutive pops on o_rd_en[2].
  - 16 o_valid beats with o_src_id=2, o_sof on beat 0, o_eof on beat 15.
- All 4 sources holding 32 words each → frame order 0,1,2,3,0,1,2,3.
  - One-cycle gap between frames; each frame's data sequence matches the corresponding source.
- Source 1 goes empty after 5 words for 10 cycles while source 3 has data → grant stays 1.
  - No pops to source 3; frame resumes and completes with 16 words total.
- i_ready deasserted for 4 cycles mid-frame → no pops and no o_valid during those cycles; frame completes intact.
- With SOCKET_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, source 0 empties after 3 words → o_abort pulses 8 cycles after the last pop.
  - Next grant goes to source 1 if it has data.
